// File: rtl/ballot_collector.sv
// Ballot collector: accepts one ballot per handshake and rejects repeat voters.
// It packs ballots into a flat vector and seals it on a full count or on close.
module ballot_collector #(
  parameter int N_VOTERS       = 16,
  parameter int CAND_W         = 2,
  parameter int ID_W           = 4,
  parameter int DEFAULT_CHOICE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vote_valid,
  output logic                       vote_ready,
  input  logic [ID_W-1:0]            vote_id,
  input  logic [CAND_W-1:0]          vote_choice,
  input  logic                       close,
  output logic                       ballot_valid,
  input  logic                       ballot_ready,
  output logic [N_VOTERS*CAND_W-1:0] ballot_bus,
  output logic [N_VOTERS-1:0]        voted_mask,
  output logic [ID_W:0]              vote_count,
  output logic                       dup_err
);

  localparam logic [CAND_W-1:0] DEF_CHOICE = CAND_W'(DEFAULT_CHOICE);
  localparam logic [ID_W:0]     FULL_COUNT = (ID_W+1)'(N_VOTERS);

  typedef enum logic {COLLECT = 1'b0, SEALED = 1'b1} state_t;

  state_t                      r_state, w_state_nxt;
  logic [N_VOTERS*CAND_W-1:0]  r_bus, w_bus_nxt;
  logic [N_VOTERS-1:0]         r_mask, w_mask_nxt;
  logic [ID_W:0]               r_count, w_count_nxt;
  logic                        r_dup, w_dup_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_bus   <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_dup   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bus   <= w_bus_nxt;
      r_mask  <= w_mask_nxt;
      r_count <= w_count_nxt;
      r_dup   <= w_dup_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bus_nxt   = r_bus;
    w_mask_nxt  = r_mask;
    w_count_nxt = r_count;
    w_dup_nxt   = 1'b0;
    case (r_state)
      COLLECT: begin
        // vote_ready is constantly 1 here, so vote_valid alone completes a handshake
        if (vote_valid) begin
          if (r_mask[vote_id]) begin
            w_dup_nxt = 1'b1;
          end else begin
            w_bus_nxt[CAND_W*int'(vote_id) +: CAND_W] = vote_choice;
            w_mask_nxt[vote_id] = 1'b1;
            w_count_nxt = r_count + 1'b1;
          end
        end
        if (close || (w_count_nxt == FULL_COUNT)) w_state_nxt = SEALED;
        // Slots still empty after this edge's ballot receive the default code
        if (close) begin
          for (int i = 0; i < N_VOTERS; i++) begin
            if (!w_mask_nxt[i]) w_bus_nxt[CAND_W*i +: CAND_W] = DEF_CHOICE;
          end
        end
      end
      SEALED: begin
        if (ballot_ready) begin
          w_state_nxt = COLLECT;
          w_bus_nxt   = '0;
          w_mask_nxt  = '0;
          w_count_nxt = '0;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  assign vote_ready   = (r_state == COLLECT);
  assign ballot_valid = (r_state == SEALED);
  assign ballot_bus   = r_bus;
  assign voted_mask   = r_mask;
  assign vote_count   = r_count;
  assign dup_err      = r_dup;

endmodule
